// File: rtl/binary_frame_loader.sv
// Thresholds a raster pixel stream to 1 bit and writes it into the binary image memory.
// Write strobe/data/address are registered one cycle after pixel acceptance; start two cycles after the final pixel.
// No backpressure: pixels are accepted whenever presented in IDLE(+SOF) or FILL, and ignored otherwise.
module binary_frame_loader #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixValid,
  input  logic       pixSof,
  input  logic [7:0] pixData,
  input  logic [7:0] pixThreshold,
  input  logic       fullImageDone,
  input  logic       frameAck,
  output logic       memWriteEnable,
  output logic       memWriteData,
  output logic [7:0] xAddressOut,
  output logic [7:0] yAddressOut,
  output logic       start,
  output logic       busy,
  output logic       frameError,
  output logic [7:0] droppedFrames
);

  // Last column/row expressed in 8 bits so a 256-wide/high image wraps at 255 by compare, not by overflow.
  localparam logic [7:0] LAST_X = 8'(IMG_W - 1);
  localparam logic [7:0] LAST_Y = 8'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_HOLD
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_col;
  logic [7:0] r_row;
  logic [7:0] w_col_next;
  logic [7:0] w_row_next;
  logic       w_wr;
  logic [7:0] w_wr_x;
  logic [7:0] w_wr_y;
  logic       w_bit;
  logic       w_err;
  logic       w_drop_inc;
  logic       w_start_next;

  logic       r_we;
  logic       r_wd;
  logic [7:0] r_x;
  logic [7:0] r_y;
  logic       r_start;
  logic       r_err;
  logic [7:0] r_drop;

  assign w_bit = (pixData > pixThreshold);

  // State register and raster counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_col   <= 8'd0;
      r_row   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_col   <= w_col_next;
      r_row   <= w_row_next;
    end
  end

  // Next state, counter advance, write request and start/drop decisions.
  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col;
    w_row_next   = r_row;
    w_wr         = 1'b0;
    w_wr_x       = 8'd0;
    w_wr_y       = 8'd0;
    w_err        = 1'b0;
    w_drop_inc   = 1'b0;
    w_start_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pixValid && pixSof) begin
          w_wr         = 1'b1;
          w_col_next   = 8'd1;
          w_row_next   = 8'd0;
          w_state_next = S_FILL;
        end
      end
      S_FILL: begin
        if (pixValid) begin
          w_wr = 1'b1;
          if (pixSof) begin
            // A new frame started before the old one finished: restart at the origin.
            w_err      = 1'b1;
            w_col_next = 8'd1;
            w_row_next = 8'd0;
          end else begin
            w_wr_x = r_col;
            w_wr_y = r_row;
            if (r_col == LAST_X) begin
              w_col_next = 8'd0;
              if (r_row == LAST_Y) begin
                w_row_next   = 8'd0;
                w_state_next = S_RUN;
              end else begin
                w_row_next = r_row + 8'd1;
              end
            end else begin
              w_col_next = r_col + 8'd1;
            end
          end
        end
      end
      S_RUN: begin
        w_start_next = 1'b1;
        w_drop_inc   = pixValid && pixSof;
        if (fullImageDone) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        // start stays up so the engine's result remains valid until the host has read it.
        w_drop_inc = pixValid && pixSof;
        if (frameAck) begin
          w_state_next = S_IDLE;
        end else begin
          w_start_next = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Registered memory write port, start, error pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_wd    <= 1'b0;
      r_x     <= 8'd0;
      r_y     <= 8'd0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
      r_drop  <= 8'd0;
    end else begin
      r_we    <= w_wr;
      r_start <= w_start_next;
      r_err   <= w_err;
      if (w_wr) begin
        r_wd <= w_bit;
        r_x  <= w_wr_x;
        r_y  <= w_wr_y;
      end
      if (w_drop_inc && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  assign memWriteEnable = r_we;
  assign memWriteData   = r_wd;
  assign xAddressOut    = r_x;
  assign yAddressOut    = r_y;
  assign start          = r_start;
  assign frameError     = r_err;
  assign droppedFrames  = r_drop;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_binary_frame_loader.sv
// Directed bench for binary_frame_loader with a pixel-index model of the frame loader.
// A 10x256 image keeps runs short while exercising a non-power-of-two column wrap and the row wrap at 255.
// Every cycle is compared against the model; literal checks pin counts, addresses and start timing.
module tb_binary_frame_loader;
  localparam int W    = 10;
  localparam int H    = 256;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixValid = 1'b0;
  logic       pixSof = 1'b0;
  logic [7:0] pixData = 8'd0;
  logic [7:0] pixThreshold = 8'd127;
  logic       fullImageDone = 1'b0;
  logic       frameAck = 1'b0;
  logic       memWriteEnable;
  logic       memWriteData;
  logic [7:0] xAddressOut;
  logic [7:0] yAddressOut;
  logic       start;
  logic       busy;
  logic       frameError;
  logic [7:0] droppedFrames;

  always #5 clk = ~clk;

  binary_frame_loader #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .pixValid(pixValid), .pixSof(pixSof), .pixData(pixData),
    .pixThreshold(pixThreshold), .fullImageDone(fullImageDone), .frameAck(frameAck),
    .memWriteEnable(memWriteEnable), .memWriteData(memWriteData), .xAddressOut(xAddressOut),
    .yAddressOut(yAddressOut), .start(start), .busy(busy), .frameError(frameError),
    .droppedFrames(droppedFrames)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: mode 0 idle, 1 filling, 2 running, 3 holding; idx counts pixels of the current frame.
  int         m_mode = 0;
  int         m_idx = 0;
  int         m_drop = 0;
  bit         m_run = 1'b0;
  int         m_start_on = 0;
  logic       exp_we, exp_wd, exp_start, exp_err, exp_busy;
  logic [7:0] exp_x, exp_y, exp_drop;

  task automatic model_wr(input int k);
    exp_we = 1'b1;
    exp_x  = 8'(k % W);
    exp_y  = 8'(k / W);
    exp_wd = (pixData > pixThreshold);
  endtask

  // Model update on every rising edge from the inputs present during the ending cycle.
  always @(posedge clk) begin
    exp_we  = 1'b0;
    exp_err = 1'b0;
    if (reset) begin
      m_mode = 0; m_idx = 0; m_drop = 0; m_run = 1'b0;
      exp_x = 8'd0; exp_y = 8'd0; exp_wd = 1'b0;
    end else begin
      case (m_mode)
        0: if (pixValid && pixSof) begin model_wr(0); m_idx = 1; m_mode = 1; end
        1: if (pixValid) begin
             if (pixSof) begin exp_err = 1'b1; model_wr(0); m_idx = 1; end
             else begin
               model_wr(m_idx);
               m_idx = m_idx + 1;
               if (m_idx == NPIX) begin m_mode = 2; m_run = 1'b1; m_start_on = cyc + 2; m_idx = 0; end
             end
           end
        2: begin
             if (pixValid && pixSof && m_drop < 255) m_drop = m_drop + 1;
             if (fullImageDone) m_mode = 3;
           end
        default: begin
             if (pixValid && pixSof && m_drop < 255) m_drop = m_drop + 1;
             if (frameAck) begin m_mode = 0; m_run = 1'b0; end
           end
      endcase
    end
    cyc = cyc + 1;
    exp_start = m_run && (cyc >= m_start_on);
    exp_busy  = (m_mode != 0);
    exp_drop  = 8'(m_drop);
  end

  int         wr_cnt = 0, ones_cnt = 0, err_cnt = 0, rise_cyc = -1, acc_cyc = 0;
  logic [7:0] last_x = 8'd0, last_y = 8'd0;
  logic       prev_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("memWriteEnable", 32'(memWriteEnable), 32'(exp_we));
    chk("start", 32'(start), 32'(exp_start));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("frameError", 32'(frameError), 32'(exp_err));
    chk("droppedFrames", 32'(droppedFrames), 32'(exp_drop));
    chk("xAddressOut", 32'(xAddressOut), 32'(exp_x));
    chk("yAddressOut", 32'(yAddressOut), 32'(exp_y));
    if (exp_we) chk("memWriteData", 32'(memWriteData), 32'(exp_wd));
    if (memWriteEnable === 1'b1) begin
      wr_cnt = wr_cnt + 1;
      ones_cnt = ones_cnt + int'(memWriteData);
      last_x = xAddressOut;
      last_y = yAddressOut;
    end
    if (frameError === 1'b1) err_cnt = err_cnt + 1;
    if (start === 1'b1 && prev_start !== 1'b1) rise_cyc = cyc;
    prev_start = start;
  endtask

  task automatic pix(input logic sof, input logic [7:0] d);
    pixValid = 1'b1; pixSof = sof; pixData = d; acc_cyc = cyc;
    tick();
    pixValid = 1'b0; pixSof = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0 && (k % 2 == 0)) tick();
      pix(k == 0, 8'(k % 256));
    end
  endtask

  task automatic finish_run();
    fullImageDone = 1'b1;
    repeat (3) tick();
    frameAck = 1'b1;
    tick();
    frameAck = 1'b0; fullImageDone = 1'b0;
    tick();
  endtask

  int w0, o0, e0;

  initial begin
    tick(); tick();
    chk("rst_we", 32'(memWriteEnable), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(droppedFrames), 32'd0);
    chk("rst_xy", {16'd0, xAddressOut, yAddressOut}, 32'd0);
    reset = 1'b0;
    tick();

    // Full frame, no gaps.
    w0 = wr_cnt; o0 = ones_cnt; rise_cyc = -1;
    send_frame(NPIX, 1'b0);
    tick(); tick();
    chk("t1_writes", 32'(wr_cnt - w0), 32'd2560);
    chk("t1_ones", 32'(ones_cnt - o0), 32'd1280);
    chk("t1_last_xy", {16'd0, last_x, last_y}, {16'd0, 8'd9, 8'd255});
    chk("t1_start_lat", 32'(rise_cyc - acc_cyc), 32'd2);

    // Three frames while running are dropped.
    w0 = wr_cnt;
    repeat (3) send_frame(NPIX, 1'b0);
    tick();
    chk("t4_drop", 32'(droppedFrames), 32'd3);
    chk("t4_writes", 32'(wr_cnt - w0), 32'd0);
    chk("t4_start", 32'(start), 32'd1);

    // Done, hold, acknowledge.
    fullImageDone = 1'b1;
    repeat (10) tick();
    chk("t5_hold_start", 32'(start), 32'd1);
    chk("t5_hold_busy", 32'(busy), 32'd1);
    frameAck = 1'b1;
    tick();
    frameAck = 1'b0; fullImageDone = 1'b0;
    chk("t5_ack_start", 32'(start), 32'd0);
    chk("t5_ack_busy", 32'(busy), 32'd0);

    // Gapped frame.
    w0 = wr_cnt; o0 = ones_cnt; e0 = err_cnt;
    send_frame(NPIX, 1'b1);
    tick(); tick();
    chk("t2_writes", 32'(wr_cnt - w0), 32'd2560);
    chk("t2_ones", 32'(ones_cnt - o0), 32'd1280);
    chk("t2_errs", 32'(err_cnt - e0), 32'd0);
    finish_run();

    // SOF on the 500th pixel restarts the frame, which then completes.
    e0 = err_cnt; rise_cyc = -1;
    send_frame(499, 1'b0);
    send_frame(NPIX, 1'b0);
    tick(); tick();
    chk("t3_errs", 32'(err_cnt - e0), 32'd1);
    chk("t3_start_lat", 32'(rise_cyc - acc_cyc), 32'd2);
    finish_run();

    // Reset in the middle of a frame.
    send_frame(1500, 1'b0);
    reset = 1'b1;
    tick();
    chk("t6_we", 32'(memWriteEnable), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_drop", 32'(droppedFrames), 32'd0);
    chk("t6_xy", {16'd0, xAddressOut, yAddressOut}, 32'd0);
    reset = 1'b0;
    tick();
    w0 = wr_cnt;
    send_frame(NPIX, 1'b0);
    tick(); tick();
    chk("t6_writes", 32'(wr_cnt - w0), 32'd2560);
    chk("t6_start", 32'(start), 32'd1);

    // Acknowledge and SOF on the same cycle: frame is dropped, rest ignored.
    fullImageDone = 1'b1;
    repeat (3) tick();
    frameAck = 1'b1; pixValid = 1'b1; pixSof = 1'b1; pixData = 8'd200;
    tick();
    frameAck = 1'b0; pixSof = 1'b0;
    w0 = wr_cnt;
    repeat (20) tick();
    pixValid = 1'b0; fullImageDone = 1'b0;
    tick();
    chk("ackx_drop", 32'(droppedFrames), 32'd1);
    chk("ackx_writes", 32'(wr_cnt - w0), 32'd0);
    chk("ackx_busy", 32'(busy), 32'd0);

    // Drop counter saturation.
    send_frame(NPIX, 1'b0);
    tick();
    repeat (258) pix(1'b1, 8'hFF);
    chk("sat_drop", 32'(droppedFrames), 32'd255);
    chk("sat_start", 32'(start), 32'd1);
    finish_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
